seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
Parallel-to-serial front end for the sequence-detector FSMs. It accepts WIDTH-bit words over a valid/ready handshake and drives one bit per clock onto the detector's serial input x. A one-entry holding buffer lets consecutive words stream with no gap bits, so patterns that straddle word boundaries stay detectable. When no word is being shifted, the output sits at a neutral idle level.

Parameters:
WIDTH, 8, bits per word; legal range 1..32.
MSB_FIRST, 1, 1 = shift MSB first; 0 = LSB first.
IDLE_BIT, 1, value driven on x when no word is shifting; 1 keeps a 0-start detector parked in its reset state.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = asserted)
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din is valid this cycle
din_ready  output  1  block can accept a word this cycle
x  output  1  serial bit to the detector's x input
x_valid  output  1  x carries a word bit (not idle fill)
frame_start  output  1  high during the cycle x carries bit 0 of a word
busy  output  1  a word is shifting or buffered

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, cnt=0, sh_reg=0, hold_full=0.
  - Outputs: x=IDLE_BIT, x_valid=0, frame_start=0, busy=0, din_ready=1.
  - Outputs take these values immediately, without waiting for a clock edge.
- Reset mid-operation: the in-flight word and the buffered word are both discarded. No residual bits appear after reset is released.
- State machine: IDLE, SHIFT.
  - Registers: sh_reg[WIDTH], cnt[max(1,clog2 WIDTH)], hold_reg[WIDTH], hold_full.
- Combinational signals:
  - accept = din_valid && din_ready.
  - din_ready = !hold_full.
  - last = (state==SHIFT) && (cnt==WIDTH-1).
  - free = (state==IDLE) || last.
- Output decode (combinational from registers only, no din-to-x path):
  - x = SHIFT ? sh_reg[MSB_FIRST ? WIDTH-1 : 0] : IDLE_BIT.
  - x_valid = (state==SHIFT).
  - frame_start = SHIFT && cnt==0.
  - busy = SHIFT || hold_full.
- Per rising edge, first matching rule wins:
  - free && hold_full: sh_reg<=hold_reg, hold_full<=0, cnt<=0, state<=SHIFT. accept is impossible on this edge because din_ready=0.
  - free && accept: sh_reg<=din (bypass, hold untouched), cnt<=0, state<=SHIFT.
  - free: state<=IDLE.
  - else (mid-word): sh_reg shifts toward the output end, zero-filled; cnt<=cnt+1.
  - Independently, accept && !free: hold_reg<=din, hold_full<=1.
- Latency:
  - A word accepted at edge k into an idle block drives its first bit in cycle k+1 and its last bit in cycle k+WIDTH.
  - If the next word is buffered before the last bit, it starts in cycle k+WIDTH+1 with zero idle cycles between words.
- Throughput: one word per WIDTH cycles sustained.
- din_valid held while din_ready=0: no accept occurs; the source must hold din stable. No data is lost or duplicated.
- WIDTH=1: every SHIFT cycle is both first and last. frame_start=1 on every valid bit.
- cnt never exceeds WIDTH-1. The transition out of SHIFT happens only via last.

Decomposition:
- Shared package seq_fsm_pkg holds:
  - state encoding localparams S_IDLE=0, S_SHIFT=1;
  - default IDLE_BIT;
  - a clog2 helper function shared with the detector FSMs.
- No sub-module: the holding buffer is one register plus a flag and stays inline.

Test Plan:
1. Reset, WIDTH=8: hold reset=0 for 3 cycles with din_valid=1 -> x=1, x_valid=0, din_ready=1, busy=0 throughout; no accept occurs.
2. Single word: din=8'hA5 accepted at edge 0 -> cycles 1..8 give x=1,0,1,0,0,1,0,1 with x_valid=1 and frame_start=1 only in cycle 1; cycle 9 gives x=1, x_valid=0, busy=0.
3. Back-to-back: 8'h66 then 8'h0F with din_valid held high -> 16 contiguous bits 0110 0110 0000 1111; din_ready=0 from the second accept until the edge ending bit 8; frame_start in cycles 1 and 9; the downstream 0110 detector enters its s4 state twice.
4. LSB first, MSB_FIRST=0: din=8'h01 -> x=1,0,0,0,0,0,0,0 over cycles 1..8.
5. Reset mid-word: reset=0 during bit 4 of 8'hFF -> x=1 and x_valid=0 in the same cycle; after release, din_ready=1, busy=0, and no further valid bits appear until a new accept.
6. Stall: three words 8'h11, 8'h22, 8'h33 with din_valid held continuously -> exactly 3 accepts; the third is accepted at edge 9 when the hold buffer drains; output is 24 gapless bits in order.

Source files
------------

// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the sequence-detector front end and detector FSMs:
// state encoding, default idle level and a constant clog2 helper.
package seq_fsm_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_BIT_DEFAULT = 1'b1;

  // Ceiling log2, intended for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per
// clock out on x, with a one-word holding buffer so consecutive words run gapless.
module seq_bit_serializer
  import seq_fsm_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam int OUT_IDX = MSB_FIRST ? (WIDTH - 1) : 0;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic accept_s;
  logic last_s;
  logic free_s;

  assign din_ready = !hold_full_q;
  assign accept_s  = din_valid && din_ready;
  assign last_s    = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
  assign free_s    = (state_q == S_IDLE) || last_s;

  // Outputs decode from registers only, so din never reaches x combinationally.
  assign x           = (state_q == S_SHIFT) ? sh_q[OUT_IDX] : IDLE_BIT;
  assign x_valid     = (state_q == S_SHIFT);
  assign frame_start = (state_q == S_SHIFT) && (cnt_q == {CW{1'b0}});
  assign busy        = (state_q == S_SHIFT) || hold_full_q;

  // Next-state: buffered word has priority over a fresh word when the shifter frees up.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (free_s && hold_full_q) begin
      sh_d        = hold_q;
      hold_full_d = 1'b0;
      cnt_d       = {CW{1'b0}};
      state_d     = S_SHIFT;
    end else if (free_s && accept_s) begin
      sh_d    = din;
      cnt_d   = {CW{1'b0}};
      state_d = S_SHIFT;
    end else if (free_s) begin
      state_d = S_IDLE;
    end else begin
      sh_d  = MSB_FIRST ? (sh_q << 1'b1) : (sh_q >> 1'b1);
      cnt_d = cnt_q + CW'(1);
    end

    // A word arriving mid-shift parks in the holding buffer.
    if (accept_s && !free_s) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      sh_q        <= {WIDTH{1'b0}};
      hold_q      <= {WIDTH{1'b0}};
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed self-checking bench for seq_bit_serializer (MSB-first and LSB-first
// instances sharing clock and reset).
module tb_seq_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] din_m, din_l;
  logic       valid_m, valid_l;
  logic       ready_m, ready_l;
  logic       x_m, x_l;
  logic       xv_m, xv_l;
  logic       fs_m, fs_l;
  logic       busy_m, busy_l;

  int tests_run;
  int tests_failed;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din_m), .din_valid(valid_m), .din_ready(ready_m),
    .x(x_m), .x_valid(xv_m), .frame_start(fs_m), .busy(busy_m)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .din(din_l), .din_valid(valid_l), .din_ready(ready_l),
    .x(x_l), .x_valid(xv_l), .frame_start(fs_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_m(input string tag);
    chk({tag, "_x"}, x_m, 1'b1);
    chk({tag, "_xv"}, xv_m, 1'b0);
    chk({tag, "_fs"}, fs_m, 1'b0);
    chk({tag, "_busy"}, busy_m, 1'b0);
    chk({tag, "_rdy"}, ready_m, 1'b1);
  endtask

  initial begin
    logic [15:0] bits16;
    logic [23:0] bits24;
    logic [7:0]  words [3];
    int          acc_cnt;
    int          third_edge;
    int          widx;
    logic        acc;

    tests_run    = 0;
    tests_failed = 0;
    reset   = 1'b0;
    din_m   = 8'hAA;
    valid_m = 1'b1;
    din_l   = 8'h00;
    valid_l = 1'b0;

    // 1: reset held with din_valid asserted
    #1;
    chk_idle_m("t1_t0");
    for (int i = 0; i < 3; i++) begin
      wait_edge();
      chk_idle_m($sformatf("t1_c%0d", i));
    end
    reset   = 1'b1;
    valid_m = 1'b0;
    wait_edge();
    chk_idle_m("t1_post");

    // 2: single word A5, MSB first
    bits16  = 16'h00A5;
    din_m   = 8'hA5;
    valid_m = 1'b1;
    wait_edge();
    valid_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_x%0d", i), x_m, bits16[7-i]);
      chk($sformatf("t2_xv%0d", i), xv_m, 1'b1);
      chk($sformatf("t2_fs%0d", i), fs_m, (i == 0));
      wait_edge();
    end
    chk_idle_m("t2_end");

    // 3: back-to-back 66 then 0F, gapless
    bits16  = 16'h660F;
    din_m   = 8'h66;
    valid_m = 1'b1;
    wait_edge();
    din_m = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_x%0d", i), x_m, bits16[15-i]);
      chk($sformatf("t3_xv%0d", i), xv_m, 1'b1);
      chk($sformatf("t3_fs%0d", i), fs_m, (i == 0) || (i == 8));
      chk($sformatf("t3_rdy%0d", i), ready_m, !((i >= 1) && (i <= 7)));
      wait_edge();
      if (i == 0) begin
        valid_m = 1'b0;
      end
    end
    chk_idle_m("t3_end");

    // 4: LSB-first instance, word 01
    din_l   = 8'h01;
    valid_l = 1'b1;
    wait_edge();
    valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_x%0d", i), x_l, (i == 0));
      chk($sformatf("t4_xv%0d", i), xv_l, 1'b1);
      chk($sformatf("t4_fs%0d", i), fs_l, (i == 0));
      wait_edge();
    end
    chk("t4_end_xv", xv_l, 1'b0);
    chk("t4_end_x", x_l, 1'b1);

    // 5: reset during bit 4 of FF with a second word buffered
    din_m   = 8'hFF;
    valid_m = 1'b1;
    wait_edge();
    din_m = 8'h81;
    wait_edge();
    valid_m = 1'b0;
    chk("t5_busy_c2", busy_m, 1'b1);
    chk("t5_rdy_c2", ready_m, 1'b0);
    wait_edge();
    wait_edge();
    chk("t5_xv_c4", xv_m, 1'b1);
    reset = 1'b0;
    #1;
    chk_idle_m("t5_rst");
    wait_edge();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_edge();
      chk($sformatf("t5_xv%0d", i), xv_m, 1'b0);
      chk($sformatf("t5_x%0d", i), x_m, 1'b1);
      chk($sformatf("t5_busy%0d", i), busy_m, 1'b0);
    end

    // 6: three words with din_valid held, source stalls on din_ready
    words[0]   = 8'h11;
    words[1]   = 8'h22;
    words[2]   = 8'h33;
    bits24     = 24'h112233;
    acc_cnt    = 0;
    third_edge = -1;
    widx       = 0;
    din_m      = words[0];
    valid_m    = 1'b1;
    for (int e = 0; e < 24; e++) begin
      acc = valid_m && ready_m;
      wait_edge();
      if (acc) begin
        acc_cnt++;
        if (acc_cnt == 3) begin
          third_edge = e;
        end
        widx++;
        if (widx < 3) begin
          din_m = words[widx];
        end else begin
          valid_m = 1'b0;
        end
      end
      chk($sformatf("t6_x%0d", e), x_m, bits24[23-e]);
      chk($sformatf("t6_xv%0d", e), xv_m, 1'b1);
      chk($sformatf("t6_fs%0d", e), fs_m, (e % 8) == 0);
    end
    chk_int("t6_accepts", acc_cnt, 3);
    chk_int("t6_third_edge", third_edge, 9);
    wait_edge();
    chk_idle_m("t6_end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
